// File: rtl/decoder_pkg.sv
// Shared types and sizing helpers for the sequential 3-to-8 one-hot decoder.
package decoder_pkg;

    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CODE_W   = 3;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    // Hold counter width; a single bit is kept even when HOLD_CYCLES <= 2.
    function automatic int unsigned cnt_width(input int unsigned hold);
        int unsigned w;
        w = $clog2(hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_3to8_comb.sv
// Purely combinational 3-bit binary to 8-bit one-hot map.
module decoder_3to8_comb
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_1hot_3to8_seq.sv
// Sequential 3-to-8 one-hot decoder: drives each accepted code for HOLD_CYCLES
// cycles, with a one-entry pending buffer for gap-free back-to-back transfers.
module decoder_1hot_3to8_seq
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CODE_W-1:0]   decoder_in,
    input  logic                decoder_in_valid,
    output logic                decoder_in_ready,
    input  logic                flush,
    output logic [ONEHOT_W-1:0] decoder_out,
    output logic                decoder_out_active,
    output logic                pending
);

    localparam int unsigned      CNT_W  = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   pend_code;
    logic [CODE_W-1:0]   load_code;
    logic [ONEHOT_W-1:0] load_onehot;
    logic                accept;

    assign decoder_in_ready = !pending && !flush;
    assign accept           = decoder_in_valid && decoder_in_ready;

    // A waiting pending code always wins over the input; ready is low then anyway.
    assign load_code = pending ? pend_code : decoder_in;

    decoder_3to8_comb u_map (
        .code   (load_code),
        .onehot (load_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            pend_code          <= '0;
            pending            <= 1'b0;
            decoder_out        <= '0;
            decoder_out_active <= 1'b0;
        end else if (flush) begin
            state              <= IDLE;
            cnt                <= '0;
            pending            <= 1'b0;
            decoder_out        <= '0;
            decoder_out_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state              <= DRIVE;
                        cnt                <= RELOAD;
                        decoder_out        <= load_onehot;
                        decoder_out_active <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (accept) begin
                            pending   <= 1'b1;
                            pend_code <= decoder_in;
                        end
                    end else if (pending || accept) begin
                        cnt         <= RELOAD;
                        pending     <= 1'b0;
                        decoder_out <= load_onehot;
                    end else begin
                        state              <= IDLE;
                        decoder_out        <= '0;
                        decoder_out_active <= 1'b0;
                    end
                end
                default: begin
                    state              <= IDLE;
                    decoder_out        <= '0;
                    decoder_out_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/decoder_1hot_3to8_seq.md
# decoder_1hot_3to8_seq

Sequential 3-to-8 one-hot decoder, the return path for our 8-to-3 one-hot encoder. It accepts a 3-bit binary code over a valid/ready handshake. It drives the matching one-hot line on a registered 8-bit output for a programmable number of cycles, then returns the output to all-zero. A one-entry pending buffer allows back-to-back codes with no idle gap. It sits between control logic producing select indices and consumers needing timed one-hot strobes (mux selects, register-file write enables).

## Interface
- HOLD_CYCLES, default 4: cycles each one-hot value is driven; legal range 1..256.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- decoder_in  input  3  binary code to decode.
- decoder_in_valid  input  1  decoder_in is valid this cycle.
- decoder_in_ready  output  1  block can accept a code this cycle.
- flush  input  1  synchronous abort; drops pending and active codes.
- decoder_out  output  8  registered one-hot output; all-zero when idle.
- decoder_out_active  output  1  high while decoder_out is non-zero.
- pending  output  1  a code is held in the pending buffer.

## Operation
- Transfer: a code is accepted on a rising edge where decoder_in_valid and decoder_in_ready are both high.
- decoder_in_ready = !pending && !flush (combinational). It is high in IDLE, and high in DRIVE while the buffer is empty.
- States:
  - IDLE: decoder_out = 8'h00.
  - DRIVE: decoder_out = 1 << code; hold counter cnt counts down from HOLD_CYCLES-1.
- IDLE, accept: load code, cnt = HOLD_CYCLES-1, go to DRIVE.
- DRIVE, cnt > 0:
  - cnt decrements each cycle.
  - An accept stores the code in the pending register (pending = 1).
- DRIVE, cnt == 0 (last cycle):
  - If pending: load the pending code, clear pending, reload cnt, stay in DRIVE.
  - Else if accept this cycle: load the incoming code directly, reload cnt, stay in DRIVE.
  - Else: go to IDLE.
- Consecutive identical codes are treated as separate transfers. The output stays continuously high on that bit for 2*HOLD_CYCLES cycles.
- flush (priority over everything):
  - Next edge: state IDLE, decoder_out = 0, pending = 0, cnt = 0.
  - No accept occurs on a flush cycle.
- decoder_out_active = (state == DRIVE), registered alongside decoder_out.
- Every 3-bit value is legal. The output is never X and never has more than one bit set.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, decoder_out = 8'h00, decoder_out_active = 0, pending = 0, cnt = 0. decoder_in_ready reads 1 after release.
- Latency: code accepted at edge k appears on decoder_out after edge k and is held through the cycle before edge k+HOLD_CYCLES.
- Back-to-back: with pending or input valid at the last DRIVE cycle, the next code appears on the following edge with zero idle cycles.
- HOLD_CYCLES = 1: a new code each cycle at full throughput. The pending register is never needed while the input is streaming.
- Reset asserted mid-DRIVE: output clears immediately (asynchronous) and the pending code is lost.
- Counter width is max(1, $clog2(HOLD_CYCLES)) bits, with no wrap-around. It reloads only on a load and otherwise stops at 0.

## Structure
- Package decoder_pkg:
  - state enum (IDLE, DRIVE).
  - ONEHOT_W = 8 and CODE_W = 3.
  - A function for counter width.
- Sub-module decoder_3to8_comb: purely combinational 3-bit to 8-bit one-hot map, instantiated once in front of the output register. The top level holds the FSM, counter and pending buffer.

## Test plan
- Reset then single code: HOLD_CYCLES=4, send 3'd5 once.
  - decoder_out = 8'h20 for exactly 4 cycles starting 1 cycle after accept, then 8'h00.
  - decoder_out_active mirrors this.
- Back-to-back with pending: send 3'd0 then 3'd7 with valid held high.
  - Second code is accepted into pending (ready drops to 0).
  - Output is 8'h01 ×4 then 8'h80 ×4 with no gap.
  - Ready returns to 1 when pending drains.
- HOLD_CYCLES=1 streaming: codes 0..7 on consecutive cycles.
  - Output is 8'h01, 02, 04 … 80 on consecutive cycles.
  - Ready stays 1 throughout.
- Flush mid-DRIVE with pending: flush asserted while driving 3'd2 with 3'd6 pending.
  - Next cycle output = 8'h00, pending = 0, state IDLE.
  - Ready = 0 during the flush cycle; no transfer is accepted.
- Asynchronous reset mid-DRIVE: assert reset_n low between edges.
  - decoder_out goes to 0 without a clock edge.
  - After release, a new code 3'd3 produces 8'h08 normally.
- Exhaustive one-hot check: all 8 codes at random gaps.
  - $onehot0(decoder_out) holds every cycle.
  - Each bit is high for exactly HOLD_CYCLES cycles per transfer.
